// File: rtl/i2s_master_ctrl_if.sv
// Sample-pair handshake between the upstream producer (master) and the I2S sequencer (slave).
// Plain valid/ready: a pair moves on any clk edge where src_valid and src_ready are both high.
interface i2s_master_ctrl_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    src_valid;
  logic                    src_ready;
  logic [SAMPLE_WIDTH-1:0] src_left;
  logic [SAMPLE_WIDTH-1:0] src_right;

  modport master (output src_valid, output src_left, output src_right, input src_ready);
  modport slave  (input src_valid, input src_left, input src_right, output src_ready);
endinterface

// File: rtl/i2s_master_ctrl.sv
// I2S master clocking plus single-entry sample buffer; loads left_in/right_in once per frame (at lrclk 1->0).
// src_ready is registered and drops while the buffer is full; I2S_MASTER_UNDERRUN_CNT_EN adds underrun_cnt.
module i2s_master_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BCLK_HALF    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  i2s_master_ctrl_if.slave        src,
  output logic                    bclk,
  output logic                    lrclk,
  output logic [SAMPLE_WIDTH-1:0] left_in,
  output logic [SAMPLE_WIDTH-1:0] right_in,
  output logic                    frame_start,
  output logic                    underrun
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int HW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } pair_t;

  logic [HW-1:0] hcnt;
  logic [BW-1:0] bitcnt;
  pair_t         hold_dat;
  logic          hold_full;
  logic          rdy_q;

  logic half_end;
  logic bit_end;
  logic load_evt;
  logic xfer;

  assign half_end      = enable && (hcnt == HW'(BCLK_HALF - 1));
  assign bit_end       = half_end && bclk && (bitcnt == BW'(SAMPLE_WIDTH - 1));
  assign load_evt      = bit_end && lrclk;
  assign xfer          = src.src_valid && rdy_q;
  assign src.src_ready = rdy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      bitcnt      <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      hold_dat    <= '0;
      hold_full   <= 1'b0;
      rdy_q       <= 1'b0;
      left_in     <= '0;
      right_in    <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (!enable) begin
        hcnt   <= '0;
        bitcnt <= '0;
        bclk   <= 1'b0;
        lrclk  <= 1'b0;
      end else if (half_end) begin
        hcnt <= '0;
        bclk <= ~bclk;
        if (bclk) begin
          if (bit_end) begin
            bitcnt <= '0;
            lrclk  <= ~lrclk;
          end else begin
            bitcnt <= bitcnt + BW'(1);
          end
        end
      end else begin
        hcnt <= hcnt + HW'(1);
      end

      if (load_evt) begin
        frame_start <= 1'b1;
        if (hold_full) begin
          left_in   <= hold_dat.left;
          right_in  <= hold_dat.right;
          hold_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end

      // xfer only happens with the buffer empty, so it never collides with a drain
      if (xfer) begin
        hold_dat  <= '{left: src.src_left, right: src.src_right};
        hold_full <= 1'b1;
      end

      // Falls on the accepting edge; rises one cycle after a drain
      rdy_q <= xfer ? 1'b0 : ~hold_full;
    end
  end

`ifdef I2S_MASTER_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (load_evt && !hold_full && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  // Underrun is reported only as the per-frame pulse in this build.
`endif

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Directed bench for i2s_master_ctrl: timing of bclk/lrclk/frame_start and a scoreboard of loaded pairs.
module tb_i2s_master_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        frame_start;
  logic        underrun;
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  i2s_master_ctrl_if #(.SAMPLE_WIDTH(16)) sif ();

  i2s_master_ctrl #(.SAMPLE_WIDTH(16), .BCLK_HALF(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .src         (sif.slave),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .left_in     (left_in),
    .right_in    (right_in),
    .frame_start (frame_start),
    .underrun    (underrun)
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          e;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          nframes = 0;
  int          exp_cnt = 0;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;
  logic        prev_lr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return bclk === 1'b1;
      1:       return bclk === 1'b0;
      2:       return lrclk === 1'b1;
      default: return frame_start === 1'b1;
    endcase
  endfunction

  task automatic wait_until(input int which, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cond(which) && n < limit);
    if (!cond(which)) begin
      checks++;
      errors++;
      $error("FAIL timeout waiting for event %0d after %0d cycles", which, n);
    end
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r, input int e);
    exp_t x;
    x.l = l;
    x.r = r;
    x.e = e;
    q.push_back(x);
  endtask

  // Scoreboard: every load event either pops a pair accepted before that edge or is an underrun.
  always @(negedge clk) begin
    exp_t p;
    if (!reset) begin
      if (frame_start) begin
        nframes++;
        chk("fs_on_lrclk_fall", {30'd0, prev_lr, lrclk}, 32'd2);
        if (q.size() > 0 && q[0].e < cyc) begin
          p = q.pop_front();
          chk("load_no_underrun", {31'd0, underrun}, 32'd0);
          chk("load_left", {16'd0, left_in}, {16'd0, p.l});
          chk("load_right", {16'd0, right_in}, {16'd0, p.r});
          last_l = p.l;
          last_r = p.r;
        end else begin
          chk("underrun_pulse", {31'd0, underrun}, 32'd1);
          chk("hold_left", {16'd0, left_in}, {16'd0, last_l});
          chk("hold_right", {16'd0, right_in}, {16'd0, last_r});
          if (exp_cnt < 65535) exp_cnt++;
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
          chk("underrun_cnt", {16'd0, underrun_cnt}, exp_cnt);
`endif
        end
      end else if (underrun) begin
        chk("underrun_without_fs", {31'd0, underrun}, {31'd0, frame_start});
      end
    end
    prev_lr = lrclk;
  end

  initial begin
    int   n;
    int   n2;
    int   t_en;
    int   lf;
    int   k;
    int   fs;
    int   acc;
    int   nf0;
    logic x;

    reset = 1'b1;
    enable = 1'b0;
    sif.src_valid = 1'b0;
    sif.src_left = '0;
    sif.src_right = '0;
    repeat (100) step();
    chk("rst_bclk", {31'd0, bclk}, 32'd0);
    chk("rst_lrclk", {31'd0, lrclk}, 32'd0);
    chk("rst_left", {16'd0, left_in}, 32'd0);
    chk("rst_right", {16'd0, right_in}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ready", {31'd0, sif.src_ready}, 32'd0);
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
    chk("rst_cnt", {16'd0, underrun_cnt}, 32'd0);
`endif
    reset = 1'b0;
    step();
    chk("ready_after_reset", {31'd0, sif.src_ready}, 32'd1);

    // Clock generation timing from enable
    enable = 1'b1;
    t_en = cyc;
    wait_until(0, 200, n);
    chk("bclk_first_rise", n, 32);
    wait_until(1, 200, n2);
    wait_until(0, 200, n);
    chk("bclk_period", n2 + n, 64);

    // Single pair before the first load
    sif.src_valid = 1'b1;
    sif.src_left = 16'h1234;
    sif.src_right = 16'hABCD;
    x = sif.src_ready;
    step();
    sif.src_valid = 1'b0;
    if (x) push_exp(16'h1234, 16'hABCD, cyc);
    chk("push_accepted", {31'd0, x}, 32'd1);
    chk("ready_low_after_push", {31'd0, sif.src_ready}, 32'd0);
    wait_until(2, 2000, n);
    chk("lrclk_rise_time", cyc - t_en, 1024);
    wait_until(3, 2000, n);
    chk("first_frame_time", cyc - t_en, 2048);
    chk("first_left", {16'd0, left_in}, 32'h1234);
    chk("first_right", {16'd0, right_in}, 32'hABCD);
    chk("ready_still_low_on_load", {31'd0, sif.src_ready}, 32'd0);
    lf = cyc;
    step();
    chk("ready_after_drain", {31'd0, sif.src_ready}, 32'd1);

    // No data for a frame: underrun, outputs hold
    wait_until(3, 2100, n);
    chk("frame_period", cyc - lf, 2048);
    chk("underrun_frame", {31'd0, underrun}, 32'd1);
    chk("underrun_hold_left", {16'd0, left_in}, 32'h1234);
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
    chk("underrun_cnt_one", {16'd0, underrun_cnt}, 32'd1);
`endif

    // Continuous valid with fresh data every cycle: one pair per frame
    sif.src_valid = 1'b1;
    k = 0;
    fs = 0;
    acc = 0;
    for (int i = 0; i < 8000 && fs < 3; i++) begin
      sif.src_left = 16'h3000 + 16'(k);
      sif.src_right = 16'hC000 + 16'(k);
      k++;
      x = sif.src_ready;
      step();
      if (x) begin
        push_exp(sif.src_left, sif.src_right, cyc);
        acc++;
      end
      if (frame_start) begin
        fs++;
        if (fs >= 2) chk("accept_per_frame", acc, 1);
        acc = 0;
      end
    end
    sif.src_valid = 1'b0;
    chk("stream_frames", fs, 3);
    lf = cyc;

    // Valid only on the load edge with an empty buffer
    while (cyc < lf + 2047) step();
    sif.src_valid = 1'b1;
    sif.src_left = 16'h5555;
    sif.src_right = 16'hAAAA;
    x = sif.src_ready;
    step();
    sif.src_valid = 1'b0;
    if (x) push_exp(16'h5555, 16'hAAAA, cyc);
    chk("coincident_accept", {31'd0, x}, 32'd1);
    chk("coincident_fs", {31'd0, frame_start}, 32'd1);
    chk("coincident_underrun", {31'd0, underrun}, 32'd1);
    wait_until(3, 2100, n);
    chk("coincident_loaded", {16'd0, left_in}, 32'h5555);
    lf = cyc;

    // Disable mid-frame with a full buffer
    step();
    sif.src_valid = 1'b1;
    sif.src_left = 16'h0F0F;
    sif.src_right = 16'hF0F0;
    x = sif.src_ready;
    step();
    sif.src_valid = 1'b0;
    if (x) push_exp(16'h0F0F, 16'hF0F0, cyc);
    while (cyc < lf + 1500) step();
    chk("lrclk_high_before_disable", {31'd0, lrclk}, 32'd1);
    enable = 1'b0;
    nf0 = nframes;
    step();
    chk("disable_bclk", {31'd0, bclk}, 32'd0);
    chk("disable_lrclk", {31'd0, lrclk}, 32'd0);
    repeat (200) step();
    chk("disable_no_frames", nframes, nf0);
    chk("disable_buffer_kept", {31'd0, sif.src_ready}, 32'd0);
    chk("disable_left_kept", {16'd0, left_in}, 32'h5555);
    enable = 1'b1;
    t_en = cyc;
    wait_until(3, 2100, n);
    chk("reenable_frame_time", cyc - t_en, 2048);
    chk("reenable_left", {16'd0, left_in}, 32'h0F0F);

    // Reset mid-frame discards the buffered pair
    repeat (2) step();
    sif.src_valid = 1'b1;
    sif.src_left = 16'h1111;
    sif.src_right = 16'h2222;
    step();
    sif.src_valid = 1'b0;
    repeat (300) step();
    reset = 1'b1;
    step();
    q.delete();
    last_l = '0;
    last_r = '0;
    exp_cnt = 0;
    chk("mid_rst_bclk", {31'd0, bclk}, 32'd0);
    chk("mid_rst_lrclk", {31'd0, lrclk}, 32'd0);
    chk("mid_rst_left", {16'd0, left_in}, 32'd0);
    chk("mid_rst_right", {16'd0, right_in}, 32'd0);
    chk("mid_rst_ready", {31'd0, sif.src_ready}, 32'd0);
`ifdef I2S_MASTER_UNDERRUN_CNT_EN
    chk("mid_rst_cnt", {16'd0, underrun_cnt}, 32'd0);
`endif
    reset = 1'b0;
    t_en = cyc;
    step();
    chk("mid_rst_ready_after", {31'd0, sif.src_ready}, 32'd1);
    wait_until(3, 2100, n);
    chk("post_rst_frame_time", cyc - t_en, 2048);
    chk("post_rst_underrun", {31'd0, underrun}, 32'd1);
    chk("post_rst_left", {16'd0, left_in}, 32'd0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
